// File: rtl/timer_pkg.sv
// Shared constants and helpers for the cascaded BCD countdown timer.
package timer_pkg;

  localparam int unsigned DIGIT_W   = 4;
  localparam logic [3:0]  BCD_MAX10 = 4'd9;
  localparam logic [3:0]  BCD_MAX6  = 4'd5;

  // Odd-index digits are tens-of-seconds / tens-of-minutes in mm:ss mode.
  function automatic logic [DIGIT_W-1:0] digit_max(input int unsigned idx, input bit sexag);
    return (sexag && idx[0]) ? BCD_MAX6 : BCD_MAX10;
  endfunction

endpackage

// File: rtl/bcd_digit_down.sv
// Single BCD down-counting digit with load and wrap-to-max on borrow.
module bcd_digit_down
  import timer_pkg::*;
(
  input  logic               clock,
  input  logic               clr,
  input  logic               load,
  input  logic [DIGIT_W-1:0] ld_val,
  input  logic               dec,
  input  logic [DIGIT_W-1:0] max,
  output logic [DIGIT_W-1:0] q,
  output logic               is_zero
);

  always_ff @(posedge clock) begin
    if (clr) begin
      q <= '0;
    end else if (load) begin
      q <= ld_val;
    end else if (dec) begin
      q <= (q == '0) ? max : q - 1'b1;
    end
  end

  assign is_zero = (q == '0);

endmodule

// File: rtl/bcd_countdown_timer.sv
// N-digit cascaded BCD down-counter with tick prescaler, load clamping and done pulse.
module bcd_countdown_timer
  import timer_pkg::*;
#(
  parameter int unsigned DIGITS      = 4,
  parameter bit          SEXAGESIMAL = 1'b1,
  parameter int unsigned TICK_DIV    = 1
) (
  input  logic                  clock,
  input  logic                  clr,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   data,
  input  logic                  en,
  output logic [4*DIGITS-1:0]   dout,
  output logic                  zero,
  output logic                  done,
  output logic                  load_err
);

  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PresLast = PW'(TICK_DIV - 1);

  logic [PW-1:0]     presc_q, presc_d;
  logic [DIGITS-1:0] is_zero;
  logic [DIGITS-1:0] dec;
  logic [DIGITS-1:0] clamped;
  logic              tick, step, last;
  logic              done_q, load_err_q;
  logic              below;

  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    localparam logic [DIGIT_W-1:0] Max = digit_max(i, SEXAGESIMAL);
    logic [DIGIT_W-1:0] din;
    logic [DIGIT_W-1:0] ld_val;

    assign din        = data[4*i +: 4];
    assign clamped[i] = (din > Max);
    assign ld_val     = clamped[i] ? Max : din;

    bcd_digit_down u_digit (
      .clock   (clock),
      .clr     (clr),
      .load    (load),
      .ld_val  (ld_val),
      .dec     (dec[i]),
      .max     (Max),
      .q       (dout[4*i +: 4]),
      .is_zero (is_zero[i])
    );
  end

  assign zero = (dout == '0);
  assign tick = (presc_q == PresLast);
  assign step = en & tick & ~zero & ~load;
  // Count is exactly one: this decrement lands on zero.
  assign last = (dout[3:0] == 4'd1) && (&is_zero[DIGITS-1:1]);

  // Borrow chain: a digit moves only when every lower digit is zero.
  always_comb begin
    below = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      dec[i] = step & below;
      below  = below & is_zero[i];
    end
  end

  always_comb begin
    presc_d = presc_q;
    if (load) begin
      presc_d = '0;
    end else if (en && !zero) begin
      presc_d = tick ? '0 : presc_q + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (clr) begin
      presc_q    <= '0;
      done_q     <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      presc_q    <= presc_d;
      done_q     <= step & last;
      load_err_q <= load & (|clamped);
    end
  end

  assign done     = done_q;
  assign load_err = load_err_q;

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Self-checking bench: directed steps then random traffic against a mixed-radix value model.
module tb_bcd_countdown_timer;

  logic        clock = 1'b0;
  logic        clr, load, en;
  logic [15:0] data;
  logic [15:0] dout_a, dout_b;
  logic        zero_a, zero_b, done_a, done_b, err_a, err_b;

  int checks = 0;
  int errors = 0;

  // Model state per instance: 0 = TICK_DIV 1, 1 = TICK_DIV 4.
  int unsigned mv[2];
  int unsigned mp[2];
  bit          md[2];
  bit          me[2];
  int unsigned div[2] = '{1, 4};

  always #5 clock = ~clock;

  bcd_countdown_timer #(.DIGITS(4), .SEXAGESIMAL(1'b1), .TICK_DIV(1)) dut_a (
    .clock(clock), .clr(clr), .load(load), .data(data), .en(en),
    .dout(dout_a), .zero(zero_a), .done(done_a), .load_err(err_a)
  );

  bcd_countdown_timer #(.DIGITS(4), .SEXAGESIMAL(1'b1), .TICK_DIV(4)) dut_b (
    .clock(clock), .clr(clr), .load(load), .data(data), .en(en),
    .dout(dout_b), .zero(zero_b), .done(done_b), .load_err(err_b)
  );

  function automatic int unsigned radix(input int i);
    return (i % 2 == 1) ? 6 : 10;
  endfunction

  function automatic logic [15:0] to_bcd(input int unsigned v);
    logic [15:0] r = '0;
    for (int i = 0; i < 4; i++) begin
      r[4*i +: 4] = 4'(v % radix(i));
      v = v / radix(i);
    end
    return r;
  endfunction

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_edge(input int k);
    if (clr) begin
      mv[k] = 0; mp[k] = 0; md[k] = 0; me[k] = 0;
    end else if (load) begin
      int unsigned v = 0, w = 1, d;
      me[k] = 0;
      for (int i = 0; i < 4; i++) begin
        d = (int'(data) >> (4 * i)) & 15;
        if (d > radix(i) - 1) begin
          d = radix(i) - 1;
          me[k] = 1;
        end
        v += d * w;
        w *= radix(i);
      end
      mv[k] = v; mp[k] = 0; md[k] = 0;
    end else begin
      md[k] = 0; me[k] = 0;
      if (en && mv[k] != 0) begin
        if (mp[k] == div[k] - 1) begin
          mp[k] = 0;
          mv[k] = mv[k] - 1;
          md[k] = (mv[k] == 0);
        end else begin
          mp[k] = mp[k] + 1;
        end
      end
    end
  endtask

  task automatic cycle(input bit c, input bit l, input logic [15:0] d, input bit e,
                       input string tag);
    clr = c; load = l; data = d; en = e;
    @(posedge clock);
    model_edge(0);
    model_edge(1);
    #1;
    check({tag, ".a.dout"}, dout_a, to_bcd(mv[0]));
    check({tag, ".a.zero"}, 16'(zero_a), 16'(mv[0] == 0));
    check({tag, ".a.done"}, 16'(done_a), 16'(md[0]));
    check({tag, ".a.err"},  16'(err_a),  16'(me[0]));
    check({tag, ".b.dout"}, dout_b, to_bcd(mv[1]));
    check({tag, ".b.zero"}, 16'(zero_b), 16'(mv[1] == 0));
    check({tag, ".b.done"}, 16'(done_b), 16'(md[1]));
    check({tag, ".b.err"},  16'(err_b),  16'(me[1]));
  endtask

  initial begin
    clr = 1'b0; load = 1'b0; data = '0; en = 1'b0;
    @(negedge clock);

    // Reset
    cycle(1, 0, 16'h0000, 0, "reset");
    check("reset.const", dout_a, 16'h0000);

    // Borrow across digits: 01:00 -> 00:59 -> 00:58
    cycle(0, 1, 16'h0100, 1, "ld0100");
    check("ld0100.const", dout_a, 16'h0100);
    cycle(0, 0, 16'h0000, 1, "dec1");
    check("dec1.const", dout_a, 16'h0059);
    cycle(0, 0, 16'h0000, 1, "dec2");
    check("dec2.const", dout_a, 16'h0058);

    // Countdown to zero and hold
    cycle(0, 1, 16'h0003, 1, "ld0003");
    for (int i = 0; i < 6; i++) cycle(0, 0, 16'h0000, 1, "tozero");

    // Clamping
    cycle(0, 1, 16'h00A7, 0, "clampA7");
    check("clampA7.const", dout_a, 16'h0057);
    cycle(0, 0, 16'h0000, 0, "errclear");
    cycle(0, 1, 16'h9999, 0, "clamp9999");
    check("clamp9999.const", dout_a, 16'h5959);

    // Load beats count; clr beats load
    cycle(0, 1, 16'h0010, 1, "ldwithen");
    cycle(0, 1, 16'h0010, 1, "ldwithen2");
    check("ldwithen.const", dout_a, 16'h0010);
    cycle(1, 1, 16'h0010, 1, "clrwithld");
    check("clrwithld.const", dout_a, 16'h0000);

    // Prescaler spacing, with a 3-cycle pause
    cycle(0, 1, 16'h0002, 1, "pre.ld");
    for (int i = 0; i < 5; i++) cycle(0, 0, 16'h0000, 1, "pre.run");
    for (int i = 0; i < 3; i++) cycle(0, 0, 16'h0000, 0, "pre.hold");
    for (int i = 0; i < 6; i++) cycle(0, 0, 16'h0000, 1, "pre.run2");

    // Random traffic
    for (int n = 0; n < 600; n++) begin
      bit c, l, e;
      logic [15:0] d;
      c = ($urandom_range(0, 63) == 0);
      l = ($urandom_range(0, 19) == 0);
      e = ($urandom_range(0, 9) < 8);
      d = 16'($urandom);
      if ($urandom_range(0, 1) == 0) d = d & 16'h0213;
      cycle(c, l, d, e, "rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
